dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter FREQ_W, default 27: frequency tuning word width, equal to the DDS desired_freq width.
REQ-002 Parameter DWELL_W, default 16: dwell counter width.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 abort  in  1  terminate the sweep; takes effect in any state.
REQ-007 cfg_start_freq  in  FREQ_W  first tuning word of the sweep.
REQ-008 cfg_stop_freq  in  FREQ_W  last tuning word of the sweep.
REQ-009 cfg_step  in  FREQ_W  tuning word increment per step.
REQ-010 cfg_dwell  in  DWELL_W  hold time per point, in units of (cfg_dwell+1) cycles.
REQ-011 cfg_mode  in  2  sweep mode: 00 single, 01 sawtooth repeat, 10 triangle repeat, 11 treated as single.
REQ-012 freq_word  out  FREQ_W  registered tuning word, drives DDS desired_freq.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 step_tick  out  1  one-cycle pulse in each cycle where freq_word takes a newly loaded value.
REQ-015 done  out  1  one-cycle pulse on normal completion of a single-mode sweep.

Function
REQ-016 States: IDLE, DWELL_UP, DWELL_DOWN, FINISH.
REQ-017 In IDLE, start=1 with abort=0 latches all cfg_* inputs; next cycle: freq_word=cfg_start_freq, step_tick=1, busy=1, state DWELL_UP, dwell counter=cfg_dwell.
REQ-018 cfg_* inputs are ignored outside the latch cycle; start while busy is ignored.
REQ-019 A latched stop below the latched start is replaced by the latched start (one-point sweep).
REQ-020 Dwell counter decrements once per cycle; the step decision is taken in the cycle it reads 0, so each point is held exactly cfg_dwell+1 cycles.
REQ-021 DWELL_UP step when freq_word < stop: next = min(freq_word+step, stop), computed at FREQ_W+1 bits so no wrap past 2^FREQ_W; step==0 jumps directly to stop.
REQ-022 DWELL_UP with freq_word == stop: single -> FINISH; sawtooth -> freq_word=start, stay DWELL_UP; triangle -> DWELL_DOWN with next = max(freq_word-step, start), no underflow; step==0 jumps to start.
REQ-023 DWELL_DOWN with freq_word == start -> DWELL_UP with next = min(start+step, stop).
REQ-024 A one-point sweep in a repeat mode reloads the same word every dwell, with step_tick each time, until abort.
REQ-025 Every freq_word load also reloads the dwell counter with cfg_dwell and pulses step_tick.
REQ-026 FINISH lasts one cycle: done=1, busy=1; next cycle IDLE, busy=0.
REQ-027 abort=1 in any non-IDLE state -> IDLE next cycle: busy=0, no done, no step_tick. abort beats start in the same cycle.
REQ-028 freq_word holds its last value in IDLE after done or abort.

Reset
REQ-029 rst_n=0 at a clock edge forces state=IDLE, freq_word=0, busy=0, done=0, step_tick=0, and dwell counter=0, including mid-sweep; takes priority over start and abort.

Structure
REQ-030 Package dds_pkg holds FREQ_W, DWELL_W, the mode encoding, and the state enum.
REQ-031 One sub-module, dds_dwell_timer: a loadable DWELL_W down-counter with a zero flag. All other logic is inline.

Verification
REQ-032 Single, start=100, stop=130, step=10, dwell=2 -> freq_word 100,110,120,130, each for 3 cycles; 4 step_ticks; done one cycle after the final dwell; busy high 13 cycles.
REQ-033 Clamp, start=0, stop=25, step=10, dwell=0, single -> 0,10,20,25, then done.
REQ-034 Triangle, start=0, stop=20, step=10, dwell=0 -> 0,10,20,10,0,10,...; abort -> busy=0 next cycle, freq_word held, no done.
REQ-035 Sawtooth top-of-range, start=0x7FFFFF0, stop=0x7FFFFFF, step=0x20 -> 0x7FFFFF0, 0x7FFFFFF, 0x7FFFFF0, ...; never wraps to a small value.
REQ-036 step=0, single, start=5, stop=9 -> 5, 9, done; start pulse during busy has no effect.
REQ-037 rst_n=0 mid-dwell -> next cycle freq_word=0, busy=0; start in the following IDLE cycle begins a fresh sweep.

Source files
------------

// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------
// dds_pkg: shared widths, sweep-mode encoding and FSM states. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package dds_pkg;

  localparam int FREQ_W  = 27;
  localparam int DWELL_W = 16;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DWELL_UP   = 2'd1,
    ST_DWELL_DOWN = 2'd2,
    ST_FINISH     = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dds_dwell_timer.sv
// ---------------------------------------------------------------
// dds_dwell_timer: loadable down-counter that parks at zero. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module dds_dwell_timer #(
  parameter int DWELL_W = dds_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------
// dds_sweep_ctrl: steps a DDS tuning word through a dwell-timed sweep. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module dds_sweep_ctrl #(
  parameter int FREQ_W  = dds_pkg::FREQ_W,
  parameter int DWELL_W = dds_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  output logic [FREQ_W-1:0]  freq_word,
  output logic               busy,
  output logic               step_tick,
  output logic               done
);

  import dds_pkg::*;

  state_t             state;
  logic [FREQ_W-1:0]  start_r;
  logic [FREQ_W-1:0]  stop_r;
  logic [FREQ_W-1:0]  step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [1:0]         mode_r;

  logic               dwell_zero;
  logic [FREQ_W:0]    up_sum;
  logic [FREQ_W:0]    down_diff;
  logic [FREQ_W-1:0]  up_next;
  logic [FREQ_W-1:0]  down_next;
  logic               at_stop;
  logic               at_start;
  logic               repeat_mode;
  logic               sweeping;
  logic               latch;
  logic               reload;
  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;

  // One extra bit on the sum/difference catches carry and borrow at the range ends.
  assign up_sum    = {1'b0, freq_word} + {1'b0, step_r};
  assign down_diff = {1'b0, freq_word} - {1'b0, step_r};
  assign up_next   = (step_r == '0 || up_sum >= {1'b0, stop_r}) ? stop_r : up_sum[FREQ_W-1:0];
  assign down_next = (step_r == '0 || down_diff[FREQ_W] || down_diff[FREQ_W-1:0] <= start_r)
                     ? start_r : down_diff[FREQ_W-1:0];

  assign at_stop     = (freq_word == stop_r);
  assign at_start    = (freq_word == start_r);
  assign repeat_mode = (mode_r == MODE_SAW) || (mode_r == MODE_TRI);
  assign sweeping    = (state == ST_DWELL_UP || state == ST_DWELL_DOWN) && !abort;
  assign latch       = (state == ST_IDLE) && start && !abort;
  assign reload      = sweeping && dwell_zero &&
                       !(state == ST_DWELL_UP && at_stop && !repeat_mode);
  assign tmr_load    = latch || reload;
  assign tmr_val     = latch ? cfg_dwell : dwell_r;

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (dwell_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      freq_word <= '0;
      busy      <= 1'b0;
      step_tick <= 1'b0;
      done      <= 1'b0;
      start_r   <= '0;
      stop_r    <= '0;
      step_r    <= '0;
      dwell_r   <= '0;
      mode_r    <= MODE_SINGLE;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (latch) begin
              start_r   <= cfg_start_freq;
              stop_r    <= (cfg_stop_freq < cfg_start_freq) ? cfg_start_freq : cfg_stop_freq;
              step_r    <= cfg_step;
              dwell_r   <= cfg_dwell;
              mode_r    <= cfg_mode;
              freq_word <= cfg_start_freq;
              step_tick <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_DWELL_UP;
            end
          end
          ST_DWELL_UP: begin
            if (dwell_zero) begin
              if (!at_stop) begin
                freq_word <= up_next;
                step_tick <= 1'b1;
              end else if (mode_r == MODE_SAW) begin
                freq_word <= start_r;
                step_tick <= 1'b1;
              end else if (mode_r == MODE_TRI) begin
                freq_word <= down_next;
                step_tick <= 1'b1;
                state     <= ST_DWELL_DOWN;
              end else begin
                done  <= 1'b1;
                state <= ST_FINISH;
              end
            end
          end
          ST_DWELL_DOWN: begin
            if (dwell_zero) begin
              step_tick <= 1'b1;
              if (at_start) begin
                freq_word <= up_next;
                state     <= ST_DWELL_UP;
              end else begin
                freq_word <= down_next;
              end
            end
          end
          ST_FINISH: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------
// tb_dds_sweep_ctrl: directed sweeps checked cycle-by-cycle against a point-list model. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_dds_sweep_ctrl;

  localparam int FW = 27;
  localparam int DW = 16;

  typedef struct {
    logic [FW-1:0] freq;
    logic          busy;
    logic          tick;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [FW-1:0] cfg_start_freq;
  logic [FW-1:0] cfg_stop_freq;
  logic [FW-1:0] cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic [FW-1:0] freq_word;
  logic          busy;
  logic          step_tick;
  logic          done;

  int     vectors = 0;
  int     miscompares = 0;
  int     busy_cnt = 0;
  int     tick_cnt = 0;
  int     done_cnt = 0;
  int     cyc = 0;
  bit     chk_en = 1'b0;
  string  tname = "reset";
  exp_t   exp_q[$];
  exp_t   tr[$];
  exp_t   idle_exp;
  exp_t   cur;
  longint pts[$];

  dds_sweep_ctrl #(.FREQ_W(FW), .DWELL_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_start_freq (cfg_start_freq),
    .cfg_stop_freq  (cfg_stop_freq),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_mode       (cfg_mode),
    .freq_word      (freq_word),
    .busy           (busy),
    .step_tick      (step_tick),
    .done           (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = idle_exp;
      vectors++;
      if (freq_word !== cur.freq || busy !== cur.busy || step_tick !== cur.tick || done !== cur.done) begin
        miscompares++;
        $display("FAIL %s cyc%0d: got freq=%h busy=%b tick=%b done=%b, want freq=%h busy=%b tick=%b done=%b",
                 tname, cyc, freq_word, busy, step_tick, done, cur.freq, cur.busy, cur.tick, cur.done);
      end
      if (busy === 1'b1) busy_cnt++;
      if (step_tick === 1'b1) tick_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  function automatic exp_t mk(input longint f, input logic b, input logic t, input logic d);
    exp_t e;
    e.freq = f[FW-1:0];
    e.busy = b;
    e.tick = t;
    e.done = d;
    return e;
  endfunction

  // Point list first, then stretched in time: every point lasts dwell+1 cycles.
  task automatic build(input longint s, input longint e, input longint st, input int dw,
                       input int md, input int max_pts);
    longint lo, hi, p;
    bit     up, fin;
    lo = s;
    hi = (e < s) ? s : e;
    p = lo;
    up = 1'b1;
    fin = 1'b0;
    pts.delete();
    tr.delete();
    pts.push_back(p);
    while (pts.size() < max_pts && !fin) begin
      if (up && p == hi) begin
        if (md == 1) p = lo;
        else if (md == 2) begin
          up = 1'b0;
          p = (st == 0 || p - st < lo) ? lo : p - st;
        end else fin = 1'b1;
      end else if (!up && p == lo) begin
        up = 1'b1;
        p = (st == 0 || p + st > hi) ? hi : p + st;
      end else if (up) p = (st == 0 || p + st > hi) ? hi : p + st;
      else p = (st == 0 || p - st < lo) ? lo : p - st;
      if (!fin) pts.push_back(p);
    end
    foreach (pts[i])
      for (int k = 0; k <= dw; k++) tr.push_back(mk(pts[i], 1'b1, k == 0, 1'b0));
    if (fin) begin
      tr.push_back(mk(hi, 1'b1, 1'b0, 1'b1));
      tr.push_back(mk(hi, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic chk(input string nm, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // kill_kind: 0 = abort, 1 = reset, asserted so that only kill_at trace entries are shown.
  task automatic do_sweep(input string nm, input longint s, input longint e, input longint st,
                          input int dw, input int md, input int mp, input int kill_at,
                          input int kill_kind, input int poke_at, input bit immediate);
    int   n, c;
    exp_t last;
    build(s, e, st, dw, md, mp);
    if (!immediate) begin
      @(negedge clk);
      #1;
    end
    tname = nm;
    n = (kill_at > 0) ? kill_at : tr.size();
    for (int i = 0; i < n; i++) exp_q.push_back(tr[i]);
    if (kill_at > 0) begin
      last = mk((kill_kind == 0) ? longint'(tr[n-1].freq) : 0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(last);
      idle_exp = last;
    end else begin
      idle_exp = tr[n-1];
    end
    busy_cnt = 0;
    tick_cnt = 0;
    done_cnt = 0;
    cfg_start_freq = s[FW-1:0];
    cfg_stop_freq  = e[FW-1:0];
    cfg_step       = st[FW-1:0];
    cfg_dwell      = dw[DW-1:0];
    cfg_mode       = md[1:0];
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    cfg_start_freq = ~cfg_start_freq;
    cfg_stop_freq  = ~cfg_stop_freq;
    cfg_step       = ~cfg_step;
    cfg_dwell      = ~cfg_dwell;
    cfg_mode       = ~cfg_mode;
    c = 0;
    while (exp_q.size() > 0 && c < 2000) begin
      abort = (kill_at > 0 && kill_kind == 0 && c == kill_at - 1);
      rst_n = !(kill_at > 0 && kill_kind == 1 && c == kill_at - 1);
      start = (c == poke_at);
      @(negedge clk);
      #1;
      c++;
    end
    abort = 1'b0;
    rst_n = 1'b1;
    start = 1'b0;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL %s timeout: %0d expected cycles left, want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_start_freq = '0;
    cfg_stop_freq  = '0;
    cfg_step       = '0;
    cfg_dwell      = '0;
    cfg_mode       = 2'b00;
    idle_exp = mk(0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    do_sweep("single", 100, 130, 10, 2, 0, 100, 0, 0, -1, 1'b0);
    chk("single_npts", pts.size(), 4);
    chk("single_p1", pts[1], 110);
    chk("single_p3", pts[3], 130);
    chk("single_busy_cycles", busy_cnt, 13);
    chk("single_ticks", tick_cnt, 4);
    chk("single_dones", done_cnt, 1);

    do_sweep("clamp", 0, 25, 10, 0, 0, 100, 0, 0, -1, 1'b0);
    chk("clamp_p2", pts[2], 20);
    chk("clamp_p3", pts[3], 25);
    chk("clamp_dones", done_cnt, 1);

    do_sweep("triangle", 0, 20, 10, 0, 2, 8, 7, 0, -1, 1'b0);
    chk("tri_p3", pts[3], 10);
    chk("tri_p4", pts[4], 0);
    chk("tri_p5", pts[5], 10);
    chk("tri_abort_dones", done_cnt, 0);

    do_sweep("sawtooth_top", 64'h7FFFFF0, 64'h7FFFFFF, 64'h20, 1, 1, 5, 9, 0, -1, 1'b0);
    chk("saw_p1", pts[1], 64'h7FFFFFF);
    chk("saw_p2", pts[2], 64'h7FFFFF0);

    do_sweep("step0_poke", 5, 9, 0, 3, 0, 100, 0, 0, 2, 1'b0);
    chk("step0_npts", pts.size(), 2);
    chk("step0_p1", pts[1], 9);

    do_sweep("one_point_tri", 50, 40, 7, 1, 2, 4, 7, 0, -1, 1'b0);
    chk("onept_p3", pts[3], 50);
    chk("onept_ticks", tick_cnt, 4);

    do_sweep("mode3_single", 3, 7, 2, 0, 3, 100, 0, 0, -1, 1'b0);
    chk("mode3_p1", pts[1], 5);

    do_sweep("reset_mid", 200, 260, 20, 4, 0, 100, 7, 1, -1, 1'b0);
    do_sweep("after_reset", 1, 3, 1, 1, 0, 100, 0, 0, -1, 1'b1);
    chk("after_reset_dones", done_cnt, 1);

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
